// File: rtl/sequential_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock,
// start/done handshake, quotient/remainder held until the next completed operation.
module sequential_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o,
  output logic [1:0]       state_dbg
);

  // Handshake: start_i is accepted only on a rising edge where the FSM is IDLE
  // (busy_o=0); done_o is a single-cycle pulse during which the results are valid.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] trial;
  logic             no_borrow;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] rem_step;
  logic             last_iter;
  logic             unused_trial_bit;

  // The shifted remainder can reach WIDTH+1 bits when the divisor is above
  // 2^(WIDTH-1), so the trial is done one bit wider again to keep the borrow exact.
  always_comb begin
    rem_shift = {rem_reg, quo_reg[WIDTH-1]};
    trial     = {1'b0, rem_shift} - {2'b00, divisor_reg};
    no_borrow = ~trial[WIDTH+1];
    quo_step  = {quo_reg[WIDTH-2:0], no_borrow};
    rem_step  = no_borrow ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  assign unused_trial_bit = trial[WIDTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_next = (divisor_i != '0) ? CALC : DONE;
        end
      end
      CALC: begin
        busy_o = 1'b1;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy_o     = 1'b1;
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      quo_reg       <= '0;
      rem_reg       <= '0;
      divisor_reg   <= '0;
      cnt           <= '0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            if (divisor_i != '0) begin
              quo_reg       <= dividend_i;
              rem_reg       <= '0;
              divisor_reg   <= divisor_i;
              cnt           <= '0;
              div_by_zero_o <= 1'b0;
            end else begin
              quotient_o    <= '1;
              remainder_o   <= dividend_i;
              div_by_zero_o <= 1'b1;
            end
          end
        end
        CALC: begin
          quo_reg <= quo_step;
          rem_reg <= rem_step;
          cnt     <= cnt + CW'(1);
          if (last_iter) begin
            quotient_o  <= quo_step;
            remainder_o <= rem_step;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_sequential_restoring_divider.sv
// Directed plus randomized checks of sequential_restoring_divider against a
// plain-arithmetic reference (n/d, n%d, all-ones on zero divisor).
module tb_sequential_restoring_divider;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] prev_q = '0;
  logic [W-1:0] prev_r = '0;

  sequential_restoring_divider #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .busy_o       (busy),
    .done_o       (done),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .div_by_zero_o(dbz),
    .state_dbg    (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one operation from IDLE; returns at #1 after the edge that leaves DONE.
  task automatic do_op(input logic [W-1:0] n, input logic [W-1:0] d, input bit hold);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    int           cyc;
    if (d == 0) begin
      eq = '1; er = n; edz = 1'b1;
    end else begin
      eq = n / d; er = n % d; edz = 1'b0;
    end
    check("idle_before_start", busy, 0);
    start = 1'b1; dividend = n; divisor = d;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    dividend = W'($urandom); divisor = W'($urandom);
    cyc = 0;
    while (!done && cyc < 40) begin
      check("busy_in_calc", busy, 1);
      check("q_held", quotient, prev_q);
      check("r_held", remainder, prev_r);
      @(posedge clk); #1;
      cyc++;
      if (hold) begin
        dividend = W'($urandom); divisor = W'($urandom);
      end
    end
    check("latency", cyc, (d == 0) ? 0 : W);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", dbz, edz);
    check("busy_in_done", busy, 1);
    if (d != 0) begin
      check("inv_qd_plus_r", quotient * d + remainder, n);
      check("inv_r_lt_d", remainder < d, 1);
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_one_pulse", done, 0);
    check("idle_after_done", busy, 0);
    check("q_after_done", quotient, eq);
    check("r_after_done", remainder, er);
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    int seen_done;
    logic [W-1:0] rn;
    logic [W-1:0] rd;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", dbz, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(8'd200, 8'd7, 1'b0);
    do_op(8'd255, 8'd1, 1'b0);
    do_op(8'd0, 8'd13, 1'b0);
    do_op(8'd5, 8'd9, 1'b0);
    do_op(8'd255, 8'd255, 1'b0);
    do_op(8'd255, 8'd128, 1'b0);
    do_op(8'd100, 8'd0, 1'b0);
    do_op(8'd9, 8'd3, 1'b0);
    do_op(8'd50, 8'd6, 1'b1);
    do_op(8'd77, 8'd10, 1'b0);

    // Reset during the fourth CALC cycle discards the operation.
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_q", quotient, 0);
    check("midrst_r", remainder, 0);
    check("midrst_dbz", dbz, 0);
    seen_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check("midrst_no_done", seen_done, 0);
    prev_q = '0;
    prev_r = '0;
    do_op(8'd17, 8'd5, 1'b0);

    for (int i = 0; i < 400; i++) begin
      rn = W'($urandom);
      rd = (i % 25 == 0) ? '0 : W'($urandom_range(1, 255));
      do_op(rn, rd, (i % 7 == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
